// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the matrix keypad scanner:
//   scan_state_t : FSM state encoding used by keypad_scanner
//   clog2w()     : ceil(log2(value)) clamped to a minimum of 1 bit, usable in
//                  constant expressions for sizing counters and ports
// -----------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN             = 2'd0,
        DEBOUNCE_PRESS   = 2'd1,
        HELD             = 2'd2,
        DEBOUNCE_RELEASE = 2'd3
    } scan_state_t;

    // Width needed to hold 'value' distinct codes. Never returns 0, so a
    // degenerate divider or counter still gets a legal one-bit vector.
    function automatic int clog2w(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : keypad_pkg

// File: rtl/keypad_debounce_counter.sv
// -----------------------------------------------------------------------------
// keypad_debounce_counter
// Counts consecutive stable clocks for one debounce window. The scanner shares
// a single instance between press and release debouncing.
//
// Ports:
//   clk   in  : clock, rising edge
//   rst   in  : synchronous active-high reset
//   load  in  : first stable clock of a window; count restarts at 1
//   step  in  : another stable clock; count increments, saturating at LIMIT
//   last  out : the current count is LIMIT-1 or more, so a step on this clock
//               completes the window
// When neither load nor step is asserted the count returns to zero.
// -----------------------------------------------------------------------------
module keypad_debounce_counter
    import keypad_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic step,
    output logic last
);

    localparam int              CW      = clog2w(LIMIT + 1);
    localparam logic [CW-1:0]   LIMIT_C = CW'(LIMIT);

    logic [CW-1:0] count;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of the others, independent of
    // evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(1);
        end else if (step) begin
            if (count != LIMIT_C) begin
                count <= count + CW'(1);
            end
        end else begin
            count <= '0;
        end
    end

    assign last = (count >= (LIMIT_C - CW'(1)));

endmodule : keypad_debounce_counter

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a NUM_ROWS x NUM_COLS switch matrix by walking a single low bit across
// the column drives, debounces presses and releases, and hands accepted keys
// to a consumer through a valid/ack pair with a sticky overrun flag.
//
// Ports:
//   clock_Value    in  : clock, rising edge
//   reset_Value    in  : synchronous active-high reset
//   rowValue       in  : [NUM_ROWS] active-low row sense, all ones = no key
//   colValue       out : [NUM_COLS] one-cold column drive
//   key_code       out : [KW] accepted key index, row*NUM_COLS + col
//   key_valid      out : key_code holds an unacknowledged key
//   key_ack        in  : consumer acknowledge
//   key_held       out : the accepted key is still physically pressed
//   key_overrun    out : sticky, a key was dropped while key_valid was high
//   debounceEnable out : FSM is debouncing a press or a release
//
// After reset the scanner stays disarmed until it has seen one complete column
// rotation with every row high. A key held down through reset is therefore
// never reported; it has to be released and pressed again.
// -----------------------------------------------------------------------------
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter  int NUM_ROWS        = 4,
    parameter  int NUM_COLS        = 4,
    parameter  int SCAN_DIVIDE     = 1,
    parameter  int DEBOUNCE_CYCLES = 16,
    localparam int KW              = clog2w(NUM_ROWS * NUM_COLS)
) (
    input  logic                clock_Value,
    input  logic                reset_Value,
    input  logic [NUM_ROWS-1:0] rowValue,
    output logic [NUM_COLS-1:0] colValue,
    output logic [KW-1:0]       key_code,
    output logic                key_valid,
    input  logic                key_ack,
    output logic                key_held,
    output logic                key_overrun,
    output logic                debounceEnable
);

    localparam int            DW       = clog2w(SCAN_DIVIDE);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIVIDE - 1);
    localparam int            AW       = clog2w(NUM_COLS * SCAN_DIVIDE);
    localparam logic [AW-1:0] ARM_LAST = AW'(NUM_COLS * SCAN_DIVIDE - 1);

    scan_state_t         state;
    logic [NUM_ROWS-1:0] captured_row;
    logic [DW-1:0]       div_cnt;
    logic [AW-1:0]       arm_cnt;
    logic                armed;

    logic                row_idle;
    logic                row_match;
    logic                cnt_load;
    logic                cnt_step;
    logic                cnt_last;
    logic [KW-1:0]       key_index;
    int                  row_sel;
    int                  col_sel;

    assign row_idle  = &rowValue;
    assign row_match = (rowValue == captured_row);

    // A window opens on the clock that first sees the new condition, so that
    // clock already counts as one stable cycle.
    assign cnt_load = ((state == SCAN) && armed && !row_idle) ||
                      ((state == HELD) && row_idle);
    assign cnt_step = ((state == DEBOUNCE_PRESS)   && row_match) ||
                      ((state == DEBOUNCE_RELEASE) && row_idle);

    keypad_debounce_counter #(
        .LIMIT (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clock_Value),
        .rst  (reset_Value),
        .load (cnt_load),
        .step (cnt_step),
        .last (cnt_last)
    );

    // Lowest-indexed low row wins when several rows are down; the column is
    // the frozen position of the zero in colValue.
    // NOTE: every variable gets a default before the loops so no path through
    // this block leaves a value unassigned, which would infer a latch.
    always_comb begin
        row_sel = 0;
        col_sel = 0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (!captured_row[r]) row_sel = r;
        end
        for (int c = 0; c < NUM_COLS; c++) begin
            if (!colValue[c]) col_sel = c;
        end
        key_index = KW'(row_sel * NUM_COLS + col_sel);
    end

    always_ff @(posedge clock_Value) begin
        if (reset_Value) begin
            state          <= SCAN;
            colValue       <= {{(NUM_COLS - 1){1'b1}}, 1'b0};
            div_cnt        <= '0;
            arm_cnt        <= '0;
            armed          <= 1'b0;
            captured_row   <= '1;
            key_code       <= '0;
            key_valid      <= 1'b0;
            key_held       <= 1'b0;
            key_overrun    <= 1'b0;
            debounceEnable <= 1'b0;
        end else begin
            // NOTE: an acknowledge clears the handshake here; a key accepted
            // later in this block on the same clock assigns key_valid again
            // and the last non-blocking assignment takes effect.
            if (key_ack && key_valid) begin
                key_valid   <= 1'b0;
                key_overrun <= 1'b0;
            end

            case (state)
                SCAN: begin
                    if (armed && !row_idle) begin
                        // Column stays frozen on the one that produced the hit.
                        captured_row   <= rowValue;
                        state          <= DEBOUNCE_PRESS;
                        debounceEnable <= 1'b1;
                    end else begin
                        if (!armed) begin
                            if (!row_idle) begin
                                arm_cnt <= '0;
                            end else if (arm_cnt == ARM_LAST) begin
                                armed <= 1'b1;
                            end else begin
                                arm_cnt <= arm_cnt + AW'(1);
                            end
                        end
                        if (div_cnt == DIV_LAST) begin
                            div_cnt  <= '0;
                            colValue <= {colValue[0], colValue[NUM_COLS-1:1]};
                        end else begin
                            div_cnt <= div_cnt + DW'(1);
                        end
                    end
                end

                DEBOUNCE_PRESS: begin
                    if (!row_match) begin
                        state          <= SCAN;
                        debounceEnable <= 1'b0;
                    end else if (cnt_last) begin
                        state          <= HELD;
                        debounceEnable <= 1'b0;
                        key_held       <= 1'b1;
                        if (!key_valid || key_ack) begin
                            key_code  <= key_index;
                            key_valid <= 1'b1;
                        end else begin
                            key_overrun <= 1'b1;
                        end
                    end
                end

                HELD: begin
                    // Extra keys pressed here leave rowValue non-idle and are
                    // simply ignored.
                    if (row_idle) begin
                        state          <= DEBOUNCE_RELEASE;
                        debounceEnable <= 1'b1;
                    end
                end

                DEBOUNCE_RELEASE: begin
                    if (!row_idle) begin
                        state          <= HELD;
                        debounceEnable <= 1'b0;
                    end else if (cnt_last) begin
                        state          <= SCAN;
                        debounceEnable <= 1'b0;
                        key_held       <= 1'b0;
                    end
                end

                default: begin
                    state          <= SCAN;
                    debounceEnable <= 1'b0;
                    key_held       <= 1'b0;
                end
            endcase
        end
    end

endmodule : keypad_scanner

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Directed bench for keypad_scanner (4x4, SCAN_DIVIDE=1, DEBOUNCE_CYCLES=16).
// A small matrix model pulls one row low whenever the pressed key's column is
// driven low, just like a real switch matrix.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

    logic       clk;
    logic       rst;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       key_held;
    logic       key_overrun;
    logic       deb_en;

    logic       press_en;
    logic [1:0] press_r;
    logic [1:0] press_c;

    int vectors     = 0;
    int miscompares = 0;
    int valid_rises = 0;
    int rises0;
    logic valid_q = 1'b0;

    keypad_scanner #(
        .NUM_ROWS        (4),
        .NUM_COLS        (4),
        .SCAN_DIVIDE     (1),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .clock_Value    (clk),
        .reset_Value    (rst),
        .rowValue       (row),
        .colValue       (col),
        .key_code       (key_code),
        .key_valid      (key_valid),
        .key_ack        (key_ack),
        .key_held       (key_held),
        .key_overrun    (key_overrun),
        .debounceEnable (deb_en)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Switch matrix: the pressed key connects its row to its column.
    always_comb begin
        row = 4'b1111;
        if (press_en && (col[press_c] == 1'b0)) row[press_r] = 1'b0;
    end

    // Counts rising edges of key_valid, sampled on the falling clock edge.
    always @(negedge clk) begin
        if (key_valid === 1'b1 && valid_q === 1'b0) valid_rises = valid_rises + 1;
        valid_q = key_valid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits (bounded) until column c is the one driven low.
    task automatic wait_col(input int c);
        int n;
        n = 0;
        while (col[c] !== 1'b0 && n < 32) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("wait_col%0d", c), 32'(col[c]), 32'd0);
    endtask

    // Presses key (r,c) once its column is driven, then runs 15 of the 16
    // debounce clocks; the caller applies the final clock.
    task automatic press_key(input logic [1:0] r, input logic [1:0] c);
        wait_col(int'(c));
        press_r  = r;
        press_c  = c;
        press_en = 1'b1;
        step(15);
        check("press_debouncing", 32'(deb_en), 32'd1);
        check("press_not_yet_valid_held", 32'(key_held), 32'd0);
    endtask

    task automatic release_key();
        press_en = 1'b0;
        step(15);
        check("release_held_during", 32'(key_held), 32'd1);
        check("release_deb_during", 32'(deb_en), 32'd1);
        step(1);
        check("release_held_after", 32'(key_held), 32'd0);
        check("release_deb_after", 32'(deb_en), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_col"},      32'(col),         32'hE);
        check({tag, "_code"},     32'(key_code),    32'd0);
        check({tag, "_valid"},    32'(key_valid),   32'd0);
        check({tag, "_held"},     32'(key_held),    32'd0);
        check({tag, "_overrun"},  32'(key_overrun), 32'd0);
        check({tag, "_deb"},      32'(deb_en),      32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        key_ack  = 1'b0;
        press_en = 1'b0;
        press_r  = 2'd0;
        press_c  = 2'd0;
        step(2);
        check_reset_values("reset");

        // Idle rotation: 1110 -> 0111 -> 1011 -> 1101 -> 1110.
        rst = 1'b0;
        step(1); check("rot0", 32'(col), 32'h7);
        step(1); check("rot1", 32'(col), 32'hB);
        step(1); check("rot2", 32'(col), 32'hD);
        step(1); check("rot3", 32'(col), 32'hE);
        check("idle_valid", 32'(key_valid), 32'd0);

        // Stable press of row 2, col 2 -> key 10.
        press_key(2'd2, 2'd2);
        check("k10_col_frozen", 32'(col), 32'hB);
        check("k10_valid_pre", 32'(key_valid), 32'd0);
        step(1);
        check("k10_valid", 32'(key_valid), 32'd1);
        check("k10_code", 32'(key_code), 32'd10);
        check("k10_held", 32'(key_held), 32'd1);
        check("k10_deb", 32'(deb_en), 32'd0);
        release_key();

        // Overrun: key 10 still unacked, press key 5.
        press_key(2'd1, 2'd1);
        step(1);
        check("ovr_code", 32'(key_code), 32'd10);
        check("ovr_flag", 32'(key_overrun), 32'd1);
        check("ovr_valid", 32'(key_valid), 32'd1);
        key_ack = 1'b1;
        step(1);
        key_ack = 1'b0;
        check("ack_valid", 32'(key_valid), 32'd0);
        check("ack_overrun", 32'(key_overrun), 32'd0);
        release_key();

        // Acknowledge on the same clock that the next key is accepted.
        press_key(2'd2, 2'd2);
        step(1);
        check("same_first_valid", 32'(key_valid), 32'd1);
        release_key();
        press_key(2'd1, 2'd1);
        key_ack = 1'b1;
        step(1);
        key_ack = 1'b0;
        check("same_valid", 32'(key_valid), 32'd1);
        check("same_code", 32'(key_code), 32'd5);
        check("same_overrun", 32'(key_overrun), 32'd0);
        release_key();

        // Bounce: 5-clock glitch on key 3, then a stable 16-clock press.
        key_ack = 1'b1;
        step(1);
        key_ack = 1'b0;
        check("bounce_pre_valid", 32'(key_valid), 32'd0);
        rises0 = valid_rises;
        wait_col(3);
        press_r  = 2'd0;
        press_c  = 2'd3;
        press_en = 1'b1;
        step(5);
        check("glitch_deb", 32'(deb_en), 32'd1);
        press_en = 1'b0;
        step(1);
        check("glitch_to_scan", 32'(deb_en), 32'd0);
        check("glitch_valid", 32'(key_valid), 32'd0);
        press_key(2'd0, 2'd3);
        step(1);
        check("bounce_valid", 32'(key_valid), 32'd1);
        check("bounce_code", 32'(key_code), 32'd3);
        release_key();
        step(1);
        check("bounce_one_event", 32'(valid_rises - rises0), 32'd1);

        // Reset while HELD; key stays down through and after reset.
        key_ack = 1'b1;
        step(1);
        key_ack = 1'b0;
        press_key(2'd2, 2'd2);
        step(1);
        check("rsth_valid", 32'(key_valid), 32'd1);
        check("rsth_held", 32'(key_held), 32'd1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_reset_values("midheld_reset");
        rises0 = valid_rises;
        step(40);
        check("locked_valid", 32'(key_valid), 32'd0);
        check("locked_deb", 32'(deb_en), 32'd0);
        check("locked_no_event", 32'(valid_rises - rises0), 32'd0);
        press_en = 1'b0;
        step(8);
        press_key(2'd2, 2'd2);
        step(1);
        check("repress_valid", 32'(key_valid), 32'd1);
        check("repress_code", 32'(key_code), 32'd10);
        release_key();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_keypad_scanner
